parity_stream_unit: RTL and testbench
=====================================

Name: parity_stream_unit

Overview:
Parametrised streaming parity generator/checker. It is the next generation of the team's fixed 3-input even-parity generator. It accepts WIDTH-bit data beats over a valid/ready handshake and accumulates parity across a frame of up to MAX_LEN beats. It emits one even- or odd-parity result per frame, compares it against a supplied parity bit and keeps a saturating error count. It sits between a data source and a link/storage interface that needs per-frame parity.

Parameters:
WIDTH, 8, data beat width in bits (>=1)
MAX_LEN, 4, maximum beats per frame; a frame force-closes on its MAX_LEN-th beat (>=1)
CNT_W, 4, width of the saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
odd_mode  input  1  0 = even parity, 1 = odd parity; latched on the first beat of each frame
in_valid  input  1  source has a beat
in_ready  output  1  block accepts a beat this cycle
in_data  input  WIDTH  data beat
in_last  input  1  final beat of the frame
par_in  input  1  expected parity bit; sampled on the closing beat
out_valid  output  1  frame result available
out_ready  input  1  sink accepts the result
out_parity  output  1  generated parity bit for the frame
out_error  output  1  out_parity != par_in
out_trunc  output  1  frame closed by MAX_LEN without in_last
out_len  output  clog2(MAX_LEN+1)  beats in the frame
err_count  output  CNT_W  saturating count of frames with out_error=1
clr_count  input  1  synchronous clear of err_count

Behaviour:
- Reset (async, rst_n=0): accumulator=0, beat count=0, latched mode=0, out_valid=0, out_parity=0, out_error=0, out_trunc=0, out_len=0, err_count=0. Reset mid-frame discards the partial frame. No result is emitted for it.
- Beat accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. The block has a single result register, combinational pass-through on the ready path.
- On each accepted non-closing beat:
  - acc <= acc ^ (XOR-reduce in_data); count <= count+1.
  - On the first beat (count=0) the block latches odd_mode.
- Closing beat is an accepted beat with in_last=1 or count==MAX_LEN-1. On the closing beat, next cycle:
  - out_valid=1.
  - out_parity = acc ^ XOR(in_data) ^ mode, where mode is the latched value, or odd_mode itself if the closing beat is also the first beat.
  - out_error = out_parity ^ par_in.
  - out_trunc = !in_last.
  - out_len = count+1.
  - acc and count return to 0.
- Latency: result visible exactly 1 cycle after the closing beat is accepted.
- Result holds stable while out_valid && !out_ready.
- If out_valid && out_ready and a closing beat is accepted in the same cycle, the new result replaces the old one with no bubble, and out_valid stays 1.
- If out_ready && out_valid with no closing beat that cycle, out_valid goes to 0 next cycle.
- err_count:
  - Increments by 1 on the cycle a result with out_error=1 is loaded.
  - Saturates at 2^CNT_W-1.
  - clr_count=1 forces 0 and has priority over a simultaneous increment.
- State machine:
  - ACCUM (count=0 or partial): transitions on beats.
  - HOLD: out_valid=1, waiting for out_ready.
  - ACCUM continues while in HOLD only when out_ready=1, per the in_ready rule above.
- No combinational path from in_data to any output.

Test Plan:
- WIDTH=8, even, single beat 8'hA5, in_last=1, par_in=0 -> next cycle out_valid=1, out_parity=0, out_error=0, out_len=1, out_trunc=0, err_count=0.
- Odd mode, beats 8'h01, 8'h03, 8'h07 (last), par_in=0 -> out_parity=1, out_error=1, out_len=3, err_count=1.
- MAX_LEN=4, even, five beats of 8'h01 with in_last never set -> first result after beat 4: out_parity=0, out_trunc=1, out_len=4. Beat 5 starts a new frame.
- Hold out_ready=0 with a result pending -> in_ready=0, outputs frozen 5 cycles. Then assert out_ready together with a single-beat frame 8'h80 (last) -> out_valid stays 1 and out_parity=1 the next cycle.
- CNT_W=4, 17 consecutive error frames -> err_count reaches 15 and stays there. Then assert clr_count on the same cycle as an error result load -> err_count=0.
- rst_n low for 1 cycle after 2 of 3 beats -> all outputs 0 asynchronously. The next 1-beat frame 8'h03 gives out_len=1 and out_parity=0.

Source files
------------

// File: rtl/parity_stream_unit_if.sv
// Stream bundle for parity_stream_unit: the beat input channel and the per-frame result channel.
// The master side is the source/sink pair and the slave side is the parity unit.
interface parity_stream_unit_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 4
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             odd_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             par_in;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic             out_error;
    logic             out_trunc;
    logic [LEN_W-1:0] out_len;

    modport master (
        output odd_mode, in_valid, in_data, in_last, par_in, out_ready,
        input  in_ready, out_valid, out_parity, out_error, out_trunc, out_len
    );

    modport slave (
        input  odd_mode, in_valid, in_data, in_last, par_in, out_ready,
        output in_ready, out_valid, out_parity, out_error, out_trunc, out_len
    );
endinterface

// File: rtl/parity_stream_unit.sv
// Streaming parity generator/checker: accumulates XOR parity over frames of up to MAX_LEN beats,
// emits one even/odd parity result per frame and keeps a saturating parity-error count.
//
// state | meaning
// ACCUM | no result pending; beats accumulate (count=0 or partial frame)
// HOLD  | result pending (out_valid=1), waiting for out_ready
module parity_stream_unit #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 4,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parity_stream_unit_if.slave  bus,
    input  logic                 clr_count,
    output logic [CNT_W-1:0]     err_count
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] beat;
    logic             beat_par;
    logic             accept;
    logic             closing;
    logic             mode_eff;
    logic             parity_nxt;
    logic             error_nxt;

    logic             acc;
    logic [LEN_W-1:0] count;
    logic             mode_lat;
    logic             res_parity;
    logic             res_error;
    logic             res_trunc;
    logic [LEN_W-1:0] res_len;

    assign beat     = bus.in_data;
    assign beat_par = ^beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b1;
        accept       = 1'b0;
        closing      = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                closing      = accept && (bus.in_last || count == LAST_IDX);
                if (closing) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                bus.in_ready = bus.out_ready;
                accept       = bus.in_valid && bus.out_ready;
                closing      = accept && (bus.in_last || count == LAST_IDX);
                // a closing beat while draining reloads the result without a bubble
                if (bus.out_ready && !closing) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // a single-beat frame has nothing latched yet, so it uses odd_mode directly
    assign mode_eff   = (count == '0) ? bus.odd_mode : mode_lat;
    assign parity_nxt = acc ^ beat_par ^ mode_eff;
    assign error_nxt  = parity_nxt ^ bus.par_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= 1'b0;
            count      <= '0;
            mode_lat   <= 1'b0;
            res_parity <= 1'b0;
            res_error  <= 1'b0;
            res_trunc  <= 1'b0;
            res_len    <= '0;
        end else if (accept) begin
            if (closing) begin
                acc        <= 1'b0;
                count      <= '0;
                res_parity <= parity_nxt;
                res_error  <= error_nxt;
                res_trunc  <= !bus.in_last;
                res_len    <= count + LEN_W'(1);
            end else begin
                acc   <= acc ^ beat_par;
                count <= count + LEN_W'(1);
                if (count == '0) begin
                    mode_lat <= bus.odd_mode;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= '0;
        end else if (closing && error_nxt && err_count != CNT_MAX) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

    assign bus.out_valid  = (state == HOLD);
    assign bus.out_parity = res_parity;
    assign bus.out_error  = res_error;
    assign bus.out_trunc  = res_trunc;
    assign bus.out_len    = res_len;
endmodule

// File: tb/tb_parity_stream_unit.sv
// Self-checking bench for parity_stream_unit: directed frames followed by random traffic,
// compared cycle by cycle against a frame-level reference model built from beat queues.
module tb_parity_stream_unit;
    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             clr_count;
    logic [CNT_W-1:0] err_count;

    parity_stream_unit_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();

    parity_stream_unit #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_count (clr_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: beats of the open frame, its mode, and the last loaded result
    logic [WIDTH-1:0] frame[$];
    logic             m_mode;
    logic             m_valid;
    logic             m_parity;
    logic             m_error;
    logic             m_trunc;
    int               m_len;
    int               m_errs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        frame.delete();
        m_mode   = 1'b0;
        m_valid  = 1'b0;
        m_parity = 1'b0;
        m_error  = 1'b0;
        m_trunc  = 1'b0;
        m_len    = 0;
        m_errs   = 0;
    endtask

    task automatic check_outputs();
        chk("out_valid",  32'(bus.out_valid),  32'(m_valid));
        chk("out_parity", 32'(bus.out_parity), 32'(m_parity));
        chk("out_error",  32'(bus.out_error),  32'(m_error));
        chk("out_trunc",  32'(bus.out_trunc),  32'(m_trunc));
        chk("out_len",    32'(bus.out_len),    32'(m_len));
        chk("err_count",  32'(err_count),      32'(m_errs));
    endtask

    // one clock cycle: drive, check readiness, advance model, check registered outputs
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic l, input logic p,
                        input logic om, input logic ordy, input logic clr);
        logic rdy;
        logic acc;
        logic close;
        logic new_err;
        int   ones;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.par_in    = p;
        bus.odd_mode  = om;
        bus.out_ready = ordy;
        clr_count     = clr;
        #1;
        rdy = !m_valid || ordy;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        acc     = v && rdy;
        close   = acc && (l || frame.size() == MAX_LEN - 1);
        new_err = 1'b0;
        if (acc) begin
            if (frame.size() == 0) m_mode = om;
            frame.push_back(d);
        end
        if (close) begin
            ones = 0;
            foreach (frame[i]) ones += $countones(frame[i]);
            m_parity = ones[0] ^ m_mode;
            m_error  = m_parity ^ p;
            m_trunc  = !l;
            m_len    = frame.size();
            m_valid  = 1'b1;
            new_err  = m_error;
            frame.delete();
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        if (clr) m_errs = 0;
        else if (new_err && m_errs < CNT_SAT) m_errs++;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        clr_count     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.par_in    = 1'b0;
        bus.odd_mode  = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #3;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single even beat
        step(1, 8'hA5, 1, 0, 0, 1, 0);
        chk("t1_parity", 32'(bus.out_parity), 32'd0);
        chk("t1_len", 32'(bus.out_len), 32'd1);

        // odd three-beat frame with mismatching par_in
        step(1, 8'h01, 0, 0, 1, 1, 0);
        step(1, 8'h03, 0, 0, 0, 1, 0);
        step(1, 8'h07, 1, 0, 0, 1, 0);
        chk("t2_parity", 32'(bus.out_parity), 32'd1);
        chk("t2_error", 32'(bus.out_error), 32'd1);
        chk("t2_len", 32'(bus.out_len), 32'd3);
        chk("t2_errcnt", 32'(err_count), 32'd1);

        // truncation at MAX_LEN, fifth beat opens a new frame
        for (int i = 0; i < 4; i++) step(1, 8'h01, 0, 0, 0, 1, 0);
        chk("t3_parity", 32'(bus.out_parity), 32'd0);
        chk("t3_trunc", 32'(bus.out_trunc), 32'd1);
        chk("t3_len", 32'(bus.out_len), 32'd4);
        step(1, 8'h01, 0, 0, 0, 1, 0);
        chk("t3_drained", 32'(bus.out_valid), 32'd0);
        step(1, 8'h01, 1, 0, 0, 0, 0);
        chk("t3_len2", 32'(bus.out_len), 32'd2);

        // backpressure: result frozen, beats refused
        for (int i = 0; i < 5; i++) begin
            step(1, 8'hFF, 1, 1, 1, 0, 0);
            chk("t4_frozen_len", 32'(bus.out_len), 32'd2);
        end
        step(1, 8'h80, 1, 1, 0, 1, 0);
        chk("t4_valid", 32'(bus.out_valid), 32'd1);
        chk("t4_parity", 32'(bus.out_parity), 32'd1);

        // saturation of the error counter, then clear beating an increment
        for (int i = 0; i < 17; i++) step(1, 8'h00, 1, 1, 0, 1, 0);
        chk("t5_sat", 32'(err_count), 32'(CNT_SAT));
        step(1, 8'h00, 1, 1, 0, 1, 1);
        chk("t5_clr", 32'(err_count), 32'd0);
        step(0, 8'h00, 0, 0, 0, 1, 0);

        // reset in the middle of a frame
        step(1, 8'h01, 0, 0, 0, 1, 0);
        step(1, 8'h01, 0, 0, 0, 1, 0);
        do_reset();
        step(1, 8'h03, 1, 0, 0, 1, 0);
        chk("t6_len", 32'(bus.out_len), 32'd1);
        chk("t6_parity", 32'(bus.out_parity), 32'd0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, WIDTH'($urandom), $urandom_range(0, 3) == 0,
                     1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 31) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
